// File: rtl/mor1kx_wb_commit_marocchino_if.sv
// Bus bundle between the MAROCCHINO write-back mux and the commit stage.
// The master side drives the registered WB-stage fields; the slave side
// (the commit stage) returns the architectural SR/ESR/EPCR/EEAR/FPCSR state
// and the flush/redirect pulses.
`ifndef OR1K_FPCSR_WIDTH
`define OR1K_FPCSR_WIDTH 12
`endif

interface mor1kx_wb_commit_marocchino_if #(
  parameter int OPTION_OPERAND_WIDTH = 32
);
  logic                            wb_new_i;
  logic [OPTION_OPERAND_WIDTH-1:0] pc_wb_i;
  logic                            wb_delay_slot_i;
  logic                            wb_flag_set_i;
  logic                            wb_flag_clear_i;
  logic                            wb_carry_set_i;
  logic                            wb_carry_clear_i;
  logic                            wb_overflow_set_i;
  logic                            wb_overflow_clear_i;
  logic                            wb_atomic_flag_set_i;
  logic                            wb_atomic_flag_clear_i;
  logic [`OR1K_FPCSR_WIDTH-1:0]    wb_fpcsr_i;
  logic                            wb_fpcsr_set_i;
  logic                            fpcsr_clr_i;
  logic                            wb_except_itlb_miss_i;
  logic                            wb_except_ipagefault_i;
  logic                            wb_except_ibus_err_i;
  logic                            wb_except_illegal_i;
  logic                            wb_except_ibus_align_i;
  logic                            wb_except_syscall_i;
  logic                            wb_except_trap_i;
  logic                            wb_except_align_i;
  logic                            wb_except_dtlb_miss_i;
  logic                            wb_except_dpagefault_i;
  logic                            wb_except_dbus_i;
  logic                            wb_excepts_en_i;
  logic                            wb_op_rfe_i;
  logic [OPTION_OPERAND_WIDTH-1:0] lsu_adr_i;

  logic                            ctrl_flag_o;
  logic                            ctrl_carry_o;
  logic                            ctrl_overflow_o;
  logic                            ctrl_atomic_flag_o;
  logic                            sr_sm_o;
  logic                            sr_dsx_o;
  logic [15:0]                     esr_o;
  logic [OPTION_OPERAND_WIDTH-1:0] epcr_o;
  logic [OPTION_OPERAND_WIDTH-1:0] eear_o;
  logic [`OR1K_FPCSR_WIDTH-1:0]    fpcsr_o;
  logic                            pipeline_flush_o;
  logic                            redirect_o;
  logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o;

  modport master (
    output wb_new_i, pc_wb_i, wb_delay_slot_i,
    output wb_flag_set_i, wb_flag_clear_i, wb_carry_set_i, wb_carry_clear_i,
    output wb_overflow_set_i, wb_overflow_clear_i,
    output wb_atomic_flag_set_i, wb_atomic_flag_clear_i,
    output wb_fpcsr_i, wb_fpcsr_set_i, fpcsr_clr_i,
    output wb_except_itlb_miss_i, wb_except_ipagefault_i, wb_except_ibus_err_i,
    output wb_except_illegal_i, wb_except_ibus_align_i, wb_except_syscall_i,
    output wb_except_trap_i, wb_except_align_i, wb_except_dtlb_miss_i,
    output wb_except_dpagefault_i, wb_except_dbus_i,
    output wb_excepts_en_i, wb_op_rfe_i, lsu_adr_i,
    input  ctrl_flag_o, ctrl_carry_o, ctrl_overflow_o, ctrl_atomic_flag_o,
    input  sr_sm_o, sr_dsx_o, esr_o, epcr_o, eear_o, fpcsr_o,
    input  pipeline_flush_o, redirect_o, redirect_pc_o
  );

  modport slave (
    input  wb_new_i, pc_wb_i, wb_delay_slot_i,
    input  wb_flag_set_i, wb_flag_clear_i, wb_carry_set_i, wb_carry_clear_i,
    input  wb_overflow_set_i, wb_overflow_clear_i,
    input  wb_atomic_flag_set_i, wb_atomic_flag_clear_i,
    input  wb_fpcsr_i, wb_fpcsr_set_i, fpcsr_clr_i,
    input  wb_except_itlb_miss_i, wb_except_ipagefault_i, wb_except_ibus_err_i,
    input  wb_except_illegal_i, wb_except_ibus_align_i, wb_except_syscall_i,
    input  wb_except_trap_i, wb_except_align_i, wb_except_dtlb_miss_i,
    input  wb_except_dpagefault_i, wb_except_dbus_i,
    input  wb_excepts_en_i, wb_op_rfe_i, lsu_adr_i,
    output ctrl_flag_o, ctrl_carry_o, ctrl_overflow_o, ctrl_atomic_flag_o,
    output sr_sm_o, sr_dsx_o, esr_o, epcr_o, eear_o, fpcsr_o,
    output pipeline_flush_o, redirect_o, redirect_pc_o
  );
endinterface

// File: rtl/mor1kx_wb_commit_marocchino.sv
// MAROCCHINO commit stage: owns SR (F/CY/OV/SM/DSX), the atomic reservation
// flag, ESR/EPCR/EEAR and FPCSR, and sequences exception entry / l.rfe return
// through a three-state FSM (IDLE -> FLUSH -> REDIRECT).
// Optional FPCSR accumulation is enabled by defining MOR1KX_WB_COMMIT_FPCSR_EN;
// without it fpcsr_o is tied to zero and the FPCSR inputs are ignored.
`ifndef OR1K_FPCSR_WIDTH
`define OR1K_FPCSR_WIDTH 12
`endif

module mor1kx_wb_commit_marocchino #(
  parameter int          OPTION_OPERAND_WIDTH = 32,
  parameter logic [31:0] OPTION_EXCEPT_BASE   = 32'h0
) (
  input logic                          clk,
  input logic                          rst,
  mor1kx_wb_commit_marocchino_if.slave cif
);
  localparam int OPW = OPTION_OPERAND_WIDTH;
  localparam int FPW = `OR1K_FPCSR_WIDTH;

  typedef enum logic [1:0] {ST_IDLE, ST_FLUSH, ST_REDIRECT} state_t;

  state_t           state;
  logic             sm;
  logic             flag;
  logic             carry;
  logic             ovf;
  logic             dsx;
  logic             atomic;
  logic [15:0]      esr;
  logic [OPW-1:0]   epcr;
  logic [OPW-1:0]   eear;
  logic [OPW-1:0]   target_p0;
  logic [OPW-1:0]   redirect_pc;
  logic             flush;
  logic             redirect;

  logic [10:0]      exc_vec;
  logic             take;
  logic             exc;
  logic             rfe;
  logic             commit;
  logic [11:0]      vec_off;
  logic             sel_syscall;
  logic             sel_dadr;
  logic [OPW-1:0]   vector;
  logic [OPW-1:0]   epcr_next;
  logic [OPW-1:0]   eear_next;

  // Set has priority over clear; with neither the bit holds.
  function automatic logic sr_bit_next(input logic cur, input logic set,
                                       input logic clr);
    if (set)
      return 1'b1;
    else if (clr)
      return 1'b0;
    else
      return cur;
  endfunction

  // SR image as saved into ESR: DSX[13], OV[11], CY[10], F[9], SM[0].
  function automatic logic [15:0] sr_image(input logic s_dsx, input logic s_ov,
                                           input logic s_cy, input logic s_f,
                                           input logic s_sm);
    logic [15:0] img;
    img     = 16'h0000;
    img[13] = s_dsx;
    img[11] = s_ov;
    img[10] = s_cy;
    img[9]  = s_f;
    img[0]  = s_sm;
    return img;
  endfunction

  // Exception flags in priority order, MSB highest.
  assign exc_vec = {cif.wb_except_itlb_miss_i,  cif.wb_except_ipagefault_i,
                    cif.wb_except_ibus_err_i,   cif.wb_except_illegal_i,
                    cif.wb_except_ibus_align_i, cif.wb_except_syscall_i,
                    cif.wb_except_trap_i,       cif.wb_except_align_i,
                    cif.wb_except_dtlb_miss_i,  cif.wb_except_dpagefault_i,
                    cif.wb_except_dbus_i};

  // A new WB insn is only accepted while the FSM is idle.
  assign take   = cif.wb_new_i & (state == ST_IDLE);
  assign exc    = take & cif.wb_excepts_en_i & (|exc_vec);
  assign rfe    = take & cif.wb_op_rfe_i & ~exc;
  assign commit = take & ~exc & ~rfe;

  // Priority encoder: vector offset, plus whether the winner is syscall or a
  // data-side fault (which decides EPCR and EEAR contents).
  always_comb begin
    vec_off     = 12'h000;
    sel_syscall = 1'b0;
    sel_dadr    = 1'b0;
    casez (exc_vec)
      11'b1??????????: vec_off = 12'hA00;
      11'b01?????????: vec_off = 12'h400;
      11'b001????????: vec_off = 12'h200;
      11'b0001???????: vec_off = 12'h700;
      11'b00001??????: vec_off = 12'h600;
      11'b000001?????: begin
        vec_off     = 12'hC00;
        sel_syscall = 1'b1;
      end
      11'b0000001????: vec_off = 12'hE00;
      11'b00000001???: begin
        vec_off  = 12'h600;
        sel_dadr = 1'b1;
      end
      11'b000000001??: begin
        vec_off  = 12'h900;
        sel_dadr = 1'b1;
      end
      11'b0000000001?: begin
        vec_off  = 12'h300;
        sel_dadr = 1'b1;
      end
      11'b00000000001: begin
        vec_off  = 12'h200;
        sel_dadr = 1'b1;
      end
      default: ;
    endcase
  end

  assign vector = OPW'(OPTION_EXCEPT_BASE) | OPW'(vec_off);

  // Delay-slot faults restart at the branch; syscall resumes past itself.
  assign epcr_next = cif.wb_delay_slot_i ? (cif.pc_wb_i - OPW'(4)) :
                     sel_syscall         ? (cif.pc_wb_i + OPW'(4)) :
                                           cif.pc_wb_i;
  assign eear_next = sel_dadr ? cif.lsu_adr_i : cif.pc_wb_i;

  // Architectural SR bits and atomic reservation.
  always_ff @(posedge clk) begin
    if (rst) begin
      sm     <= 1'b1;
      flag   <= 1'b0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      dsx    <= 1'b0;
      atomic <= 1'b0;
    end else if (exc) begin
      sm     <= 1'b1;
      dsx    <= cif.wb_delay_slot_i;
      atomic <= 1'b0;
    end else if (rfe) begin
      sm     <= esr[0];
      flag   <= esr[9];
      carry  <= esr[10];
      ovf    <= esr[11];
      dsx    <= esr[13];
    end else if (commit) begin
      flag   <= sr_bit_next(flag,   cif.wb_flag_set_i,        cif.wb_flag_clear_i);
      carry  <= sr_bit_next(carry,  cif.wb_carry_set_i,       cif.wb_carry_clear_i);
      ovf    <= sr_bit_next(ovf,    cif.wb_overflow_set_i,    cif.wb_overflow_clear_i);
      atomic <= sr_bit_next(atomic, cif.wb_atomic_flag_set_i, cif.wb_atomic_flag_clear_i);
    end
  end

  // Exception context registers, captured on exception entry only.
  always_ff @(posedge clk) begin
    if (rst) begin
      esr  <= 16'h0000;
      epcr <= '0;
      eear <= '0;
    end else if (exc) begin
      esr  <= sr_image(dsx, ovf, carry, flag, sm);
      epcr <= epcr_next;
      eear <= eear_next;
    end
  end

  // Redirect target held while the flush drains.
  always_ff @(posedge clk) begin
    if (exc)
      target_p0 <= vector;
    else if (rfe)
      target_p0 <= epcr;
  end

  // Exception/RFE sequencer with registered flush and redirect pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      flush       <= 1'b0;
      redirect    <= 1'b0;
      redirect_pc <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          redirect <= 1'b0;
          if (exc | rfe) begin
            state <= ST_FLUSH;
            flush <= 1'b1;
          end
        end
        ST_FLUSH: begin
          flush       <= 1'b0;
          redirect    <= 1'b1;
          redirect_pc <= target_p0;
          state       <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          redirect <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          flush    <= 1'b0;
          redirect <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef MOR1KX_WB_COMMIT_FPCSR_EN
  logic [FPW-1:0] fpcsr;
  logic [FPW-1:3] fp_flags_cleared;
  logic           fp_acc;

  assign fp_acc           = take & ~exc & cif.wb_fpcsr_set_i;
  assign fp_flags_cleared = cif.fpcsr_clr_i ? '0 : fpcsr[FPW-1:3];

  // Sticky FPU flags: clear first, then OR in the new WB flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpcsr <= '0;
    end else if (fp_acc) begin
      fpcsr[FPW-1:3] <= fp_flags_cleared | cif.wb_fpcsr_i[FPW-1:3];
      fpcsr[2:0]     <= cif.wb_fpcsr_i[2:0];
    end else begin
      fpcsr[FPW-1:3] <= fp_flags_cleared;
    end
  end

  assign cif.fpcsr_o = fpcsr;
`else
  logic unused_fpcsr;
  assign unused_fpcsr = ^{cif.wb_fpcsr_i, cif.wb_fpcsr_set_i, cif.fpcsr_clr_i};
  assign cif.fpcsr_o  = '0;
`endif

  assign cif.ctrl_flag_o        = flag;
  assign cif.ctrl_carry_o       = carry;
  assign cif.ctrl_overflow_o    = ovf;
  assign cif.ctrl_atomic_flag_o = atomic;
  assign cif.sr_sm_o            = sm;
  assign cif.sr_dsx_o           = dsx;
  assign cif.esr_o              = esr;
  assign cif.epcr_o             = epcr;
  assign cif.eear_o             = eear;
  assign cif.pipeline_flush_o   = flush;
  assign cif.redirect_o         = redirect;
  assign cif.redirect_pc_o      = redirect_pc;
endmodule

// File: tb/tb_mor1kx_wb_commit_marocchino.sv
// Bench for the MAROCCHINO commit stage: directed scenarios followed by
// randomized WB transactions, checked against a transaction-level model of
// the architectural state and the flush/redirect sequence.
module tb_mor1kx_wb_commit_marocchino;
  localparam int OPW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mor1kx_wb_commit_marocchino_if #(.OPTION_OPERAND_WIDTH(OPW)) cif ();

  mor1kx_wb_commit_marocchino #(
    .OPTION_OPERAND_WIDTH(OPW),
    .OPTION_EXCEPT_BASE  (32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cif(cif)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // model of architectural state
  logic        m_sm, m_f, m_cy, m_ov, m_dsx, m_at;
  logic [15:0] m_esr;
  logic [31:0] m_epcr, m_eear;
  logic [11:0] m_fpcsr;

  // stimulus fields of the next WB insn
  logic [31:0] t_pc, t_lsu;
  logic        t_ds, t_en, t_rfe, t_fpset;
  logic [7:0]  t_upd;  // {fs, fc, cs, cc, os, oc, as, ac}
  logic [10:0] t_ex;   // itlb..dbus, MSB highest priority
  logic [11:0] t_fp;

  logic [11:0] off_tab [11];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_arch(input string tag);
    chk({tag, "_flag"},  32'(cif.ctrl_flag_o),        32'(m_f));
    chk({tag, "_carry"}, 32'(cif.ctrl_carry_o),       32'(m_cy));
    chk({tag, "_ov"},    32'(cif.ctrl_overflow_o),    32'(m_ov));
    chk({tag, "_atom"},  32'(cif.ctrl_atomic_flag_o), 32'(m_at));
    chk({tag, "_sm"},    32'(cif.sr_sm_o),            32'(m_sm));
    chk({tag, "_dsx"},   32'(cif.sr_dsx_o),           32'(m_dsx));
    chk({tag, "_esr"},   32'(cif.esr_o),              32'(m_esr));
    chk({tag, "_epcr"},  cif.epcr_o,                  m_epcr);
    chk({tag, "_eear"},  cif.eear_o,                  m_eear);
    chk({tag, "_fpcsr"}, 32'(cif.fpcsr_o),            32'(m_fpcsr));
  endtask

  task automatic clr_stim();
    t_pc = '0; t_lsu = '0; t_ds = 1'b0; t_en = 1'b0; t_rfe = 1'b0;
    t_fpset = 1'b0; t_upd = '0; t_ex = '0; t_fp = '0;
  endtask

  task automatic apply();
    cif.pc_wb_i                = t_pc;
    cif.lsu_adr_i              = t_lsu;
    cif.wb_delay_slot_i        = t_ds;
    cif.wb_flag_set_i          = t_upd[7];
    cif.wb_flag_clear_i        = t_upd[6];
    cif.wb_carry_set_i         = t_upd[5];
    cif.wb_carry_clear_i       = t_upd[4];
    cif.wb_overflow_set_i      = t_upd[3];
    cif.wb_overflow_clear_i    = t_upd[2];
    cif.wb_atomic_flag_set_i   = t_upd[1];
    cif.wb_atomic_flag_clear_i = t_upd[0];
    cif.wb_except_itlb_miss_i  = t_ex[10];
    cif.wb_except_ipagefault_i = t_ex[9];
    cif.wb_except_ibus_err_i   = t_ex[8];
    cif.wb_except_illegal_i    = t_ex[7];
    cif.wb_except_ibus_align_i = t_ex[6];
    cif.wb_except_syscall_i    = t_ex[5];
    cif.wb_except_trap_i       = t_ex[4];
    cif.wb_except_align_i      = t_ex[3];
    cif.wb_except_dtlb_miss_i  = t_ex[2];
    cif.wb_except_dpagefault_i = t_ex[1];
    cif.wb_except_dbus_i       = t_ex[0];
    cif.wb_excepts_en_i        = t_en;
    cif.wb_op_rfe_i            = t_rfe;
    cif.wb_fpcsr_i             = t_fp;
    cif.wb_fpcsr_set_i         = t_fpset;
  endtask

  task automatic model_reset();
    m_sm = 1'b1; m_f = 1'b0; m_cy = 1'b0; m_ov = 1'b0; m_dsx = 1'b0; m_at = 1'b0;
    m_esr = '0; m_epcr = '0; m_eear = '0; m_fpcsr = '0;
  endtask

  // Issue the current stimulus as one WB insn and follow it to completion.
  task automatic fire(input string tag);
    logic        is_exc, is_rfe;
    int          sel;
    logic [31:0] tgt;
    apply();
    is_exc = t_en && (t_ex != '0);
    is_rfe = t_rfe && !is_exc;
    sel = -1;
    for (int i = 10; i >= 0; i--)
      if (sel < 0 && t_ex[i]) sel = i;
    tgt = '0;
    if (is_exc) begin
      m_esr  = {2'b00, m_dsx, 1'b0, m_ov, m_cy, m_f, 8'h00, m_sm};
      m_sm   = 1'b1;
      m_dsx  = t_ds;
      m_at   = 1'b0;
      m_epcr = t_ds ? t_pc - 32'd4 : ((sel == 5) ? t_pc + 32'd4 : t_pc);
      m_eear = (sel <= 3) ? t_lsu : t_pc;
      tgt    = {20'h0, off_tab[sel]};
    end else if (is_rfe) begin
      m_sm  = m_esr[0];
      m_f   = m_esr[9];
      m_cy  = m_esr[10];
      m_ov  = m_esr[11];
      m_dsx = m_esr[13];
      tgt   = m_epcr;
    end else begin
      m_f  = t_upd[7] ? 1'b1 : (t_upd[6] ? 1'b0 : m_f);
      m_cy = t_upd[5] ? 1'b1 : (t_upd[4] ? 1'b0 : m_cy);
      m_ov = t_upd[3] ? 1'b1 : (t_upd[2] ? 1'b0 : m_ov);
      m_at = t_upd[1] ? 1'b1 : (t_upd[0] ? 1'b0 : m_at);
    end
`ifdef MOR1KX_WB_COMMIT_FPCSR_EN
    if (!is_exc && t_fpset) begin
      m_fpcsr[11:3] = m_fpcsr[11:3] | t_fp[11:3];
      m_fpcsr[2:0]  = t_fp[2:0];
    end
`endif
    cif.wb_new_i = 1'b1;
    @(posedge clk); #1;
    cif.wb_new_i = 1'b0;
    check_arch(tag);
    if (is_exc || is_rfe) begin
      chk({tag, "_flush1"}, 32'(cif.pipeline_flush_o), 32'd1);
      chk({tag, "_redir1"}, 32'(cif.redirect_o),       32'd0);
      // a WB insn arriving while busy must be ignored
      t_upd = 8'hAA; t_ex = 11'h7FF; t_en = 1'b1; t_rfe = 1'b1;
      t_fp = 12'hFFF; t_fpset = 1'b1; t_ds = 1'b1;
      apply();
      cif.wb_new_i = 1'b1;
      @(posedge clk); #1;
      chk({tag, "_flush2"}, 32'(cif.pipeline_flush_o), 32'd0);
      chk({tag, "_redir2"}, 32'(cif.redirect_o),       32'd1);
      chk({tag, "_rpc"},    cif.redirect_pc_o,         tgt);
      check_arch({tag, "_busy"});
      @(posedge clk); #1;
      cif.wb_new_i = 1'b0;
      chk({tag, "_flush3"}, 32'(cif.pipeline_flush_o), 32'd0);
      chk({tag, "_redir3"}, 32'(cif.redirect_o),       32'd0);
      check_arch({tag, "_done"});
    end else begin
      chk({tag, "_flush"}, 32'(cif.pipeline_flush_o), 32'd0);
      chk({tag, "_redir"}, 32'(cif.redirect_o),       32'd0);
    end
  endtask

  initial begin
    int gap;
    off_tab[10] = 12'hA00; off_tab[9] = 12'h400; off_tab[8] = 12'h200;
    off_tab[7]  = 12'h700; off_tab[6] = 12'h600; off_tab[5] = 12'hC00;
    off_tab[4]  = 12'hE00; off_tab[3] = 12'h600; off_tab[2] = 12'h900;
    off_tab[1]  = 12'h300; off_tab[0] = 12'h200;

    rst = 1'b1;
    cif.wb_new_i = 1'b0;
    cif.fpcsr_clr_i = 1'b0;
    clr_stim();
    apply();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_arch("reset");
    chk("reset_flush", 32'(cif.pipeline_flush_o), 32'd0);
    chk("reset_redir", 32'(cif.redirect_o),       32'd0);
    chk("reset_rpc",   cif.redirect_pc_o,         32'd0);
    chk("reset_sm",    32'(cif.sr_sm_o),          32'd1);

    // flag set, carry set+clear together
    clr_stim(); t_upd = 8'b1011_0000;
    fire("t1");
    chk("t1_flag_c",  32'(cif.ctrl_flag_o),  32'd1);
    chk("t1_carry_c", 32'(cif.ctrl_carry_o), 32'd1);

    clr_stim(); t_upd = 8'b0001_0000;
    fire("cyclr");

    // syscall in delay slot, trap also flagged
    clr_stim(); t_pc = 32'h2004; t_ds = 1'b1; t_ex = 11'b000_0011_0000; t_en = 1'b1;
    fire("sys");
    chk("sys_epcr_c", cif.epcr_o,             32'h2000);
    chk("sys_dsx_c",  32'(cif.sr_dsx_o),      32'd1);
    chk("sys_vec_c",  cif.redirect_pc_o,      32'h0C00);
    chk("sys_esr_c",  32'(cif.esr_o),         32'h0201);

    clr_stim(); t_upd = 8'b0100_0000;
    fire("fclr");

    // dtlb miss with a flag set that must be dropped
    clr_stim(); t_pc = 32'h3000; t_ex = 11'b000_0000_0100; t_en = 1'b1;
    t_lsu = 32'hDEAD_0000; t_upd = 8'h80;
    fire("dtlb");
    chk("dtlb_eear_c", cif.eear_o,            32'hDEAD_0000);
    chk("dtlb_flag_c", 32'(cif.ctrl_flag_o),  32'd0);
    chk("dtlb_vec_c",  cif.redirect_pc_o,     32'h0900);

    clr_stim(); t_upd = 8'h82;
    fire("fset");

    // illegal insn at 0x1000 with F=1 and a live reservation
    clr_stim(); t_pc = 32'h1000; t_ex = 11'b000_1000_0000; t_en = 1'b1;
    fire("ill");
    chk("ill_epcr_c", cif.epcr_o,                   32'h1000);
    chk("ill_esr_c",  32'(cif.esr_o),               32'h0201);
    chk("ill_atom_c", 32'(cif.ctrl_atomic_flag_o),  32'd0);
    chk("ill_vec_c",  cif.redirect_pc_o,            32'h0700);

    // return from exception
    clr_stim(); t_rfe = 1'b1;
    fire("rfe");
    chk("rfe_flag_c", 32'(cif.ctrl_flag_o), 32'd1);
    chk("rfe_sm_c",   32'(cif.sr_sm_o),     32'd1);
    chk("rfe_rpc_c",  cif.redirect_pc_o,    32'h1000);

`ifdef MOR1KX_WB_COMMIT_FPCSR_EN
    clr_stim(); t_fpset = 1'b1; t_fp = 12'h008;
    fire("fp1");
    t_fp = 12'h010;
    fire("fp2");
    chk("fp_acc_c", 32'(cif.fpcsr_o & 12'hFF8), 32'h018);
    cif.fpcsr_clr_i = 1'b1;
    @(posedge clk); #1;
    cif.fpcsr_clr_i = 1'b0;
    m_fpcsr[11:3] = '0;
    chk("fp_clr_c", 32'(cif.fpcsr_o & 12'hFF8), 32'h000);
    check_arch("fpclr");
    clr_stim(); t_fpset = 1'b1; t_fp = 12'h040;
    fire("fp3");
    clr_stim(); t_fpset = 1'b1; t_fp = 12'h025;
    cif.fpcsr_clr_i = 1'b1;
    m_fpcsr[11:3] = '0;
    fire("fpcs");
    cif.fpcsr_clr_i = 1'b0;
    chk("fp_clrset_c", 32'(cif.fpcsr_o), 32'h025);
`else
    clr_stim(); t_fpset = 1'b1; t_fp = 12'hFFF;
    fire("fpoff");
`endif

    // randomized WB traffic
    for (int n = 0; n < 250; n++) begin
      clr_stim();
      t_pc    = $urandom & 32'hFFFF_FFFC;
      t_lsu   = $urandom;
      t_ds    = 1'($urandom_range(0, 1));
      t_upd   = 8'($urandom);
      t_ex    = ($urandom_range(0, 2) == 0) ? 11'($urandom) : 11'h000;
      t_en    = 1'($urandom_range(0, 1));
      t_rfe   = ($urandom_range(0, 4) == 0);
      t_fp    = 12'($urandom);
      t_fpset = 1'($urandom_range(0, 1));
      fire("rnd");
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        check_arch("gap");
      end
    end

    // reset while the flush is pending: no redirect may follow
    clr_stim(); t_pc = 32'h4000; t_ex = 11'b000_1000_0000; t_en = 1'b1;
    apply();
    cif.wb_new_i = 1'b1;
    @(posedge clk); #1;
    cif.wb_new_i = 1'b0;
    chk("rstf_flush1", 32'(cif.pipeline_flush_o), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("rstf_flush2", 32'(cif.pipeline_flush_o), 32'd0);
    chk("rstf_redir2", 32'(cif.redirect_o),       32'd0);
    chk("rstf_rpc",    cif.redirect_pc_o,         32'd0);
    check_arch("rstf");
    @(posedge clk); #1;
    chk("rstf_redir3", 32'(cif.redirect_o),       32'd0);
    clr_stim(); t_upd = 8'b0010_1000;
    fire("post");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mor1kx_wb_commit_marocchino.md
# mor1kx_wb_commit_marocchino

Commit stage for the MAROCCHINO pipeline, directly downstream of the RF write-back mux. It consumes the registered WB-stage flags, FPCSR bits, exception flags and RFE marker, and maintains the architectural SR, ESR, EPCR, EEAR and FPCSR state. A three-state FSM sequences exception entry and RFE return: pipeline flush, then redirect of fetch to the handler vector or to EPCR.

## Interface
Parameters:
- OPTION_OPERAND_WIDTH, 32, PC/address width
- OPTION_EXCEPT_BASE, 32'h0, exception vector base, OR'd with vector offset

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- wb_new_i  in  1  pulse, one cycle after padv_wb; WB registers hold a newly advanced insn
- pc_wb_i  in  OPW  PC of WB insn
- wb_delay_slot_i  in  1  WB insn is in delay slot
- wb_flag_set_i, wb_flag_clear_i, wb_carry_set_i, wb_carry_clear_i, wb_overflow_set_i, wb_overflow_clear_i  in  1 each  SR bit updates
- wb_atomic_flag_set_i, wb_atomic_flag_clear_i  in  1 each  atomic reservation updates
- wb_fpcsr_i  in  `OR1K_FPCSR_WIDTH  FPU flag bits
- wb_fpcsr_set_i  in  1  accumulate wb_fpcsr_i
- fpcsr_clr_i  in  1  clear FPCSR flag bits (MTSPR path)
- wb_except_{itlb_miss, ipagefault, ibus_err, illegal, ibus_align, syscall, trap, align, dtlb_miss, dpagefault, dbus}_i  in  1 each  exception flags
- wb_excepts_en_i  in  1  exception flags qualified
- wb_op_rfe_i  in  1  l.rfe in WB
- lsu_adr_i  in  OPW  faulting data address
- ctrl_flag_o, ctrl_carry_o, ctrl_overflow_o, ctrl_atomic_flag_o  out  1 each  architectural bits
- sr_sm_o, sr_dsx_o  out  1 each  supervisor mode, delay-slot-exception bit
- esr_o  out  16  saved SR image {DSX[13], OV[11], CY[10], F[9], SM[0]}, other bits 0
- epcr_o, eear_o  out  OPW  saved PC / effective address
- fpcsr_o  out  `OR1K_FPCSR_WIDTH  FPCSR
- pipeline_flush_o  out  1  one-cycle flush pulse
- redirect_o  out  1  one-cycle fetch redirect pulse
- redirect_pc_o  out  OPW  redirect target, valid with redirect_o

## Operation
- Trigger: wb_new_i in IDLE. EXC = wb_excepts_en_i & (any exception flag). RFE = wb_op_rfe_i & ~EXC.
- Normal commit (wb_new_i, ~EXC, ~RFE): for each SR bit, set wins over clear; otherwise hold. Atomic flag: set wins over clear.
- EXC has priority over flag/atomic updates; updates from that insn are dropped. On entry:
  - ctrl_atomic_flag_o <= 0.
  - ESR <= current SR image; SM <= 1; DSX <= wb_delay_slot_i.
  - EPCR <= pc_wb_i - 4 if in delay slot; else pc_wb_i + 4 for syscall; else pc_wb_i.
  - EEAR <= lsu_adr_i for align/dtlb/dpagefault/dbus; else pc_wb_i.
- Exception priority (high to low) and vector offset: itlb_miss A00, ipagefault 400, ibus_err 200, illegal 700, ibus_align 600, syscall C00, trap E00, align 600, dtlb_miss 900, dpagefault 300, dbus 200.
- RFE: {SM, F, CY, OV, DSX} <= ESR fields; target = epcr_o.
- FSM:
  - IDLE -> FLUSH on EXC or RFE; target latched.
  - FLUSH: pipeline_flush_o = 1 -> REDIRECT.
  - REDIRECT: redirect_o = 1, redirect_pc_o = target -> IDLE.
- wb_new_i outside IDLE is ignored; all state holds.
- Reset values:
  - SM = 1; F, CY, OV, DSX, atomic = 0.
  - esr_o, epcr_o, eear_o, fpcsr_o, redirect_pc_o = 0.
  - pipeline_flush_o, redirect_o = 0; FSM = IDLE.

## Timing
- SR/atomic updates are visible the cycle after wb_new_i.
- Exception/RFE: the ESR/EPCR/EEAR/SR update is visible at cycle T+1 (T = trigger cycle). Flush pulses at T+1 and redirect at T+2. A new trigger is possible at T+3 at the earliest.
- rst asserted in FLUSH/REDIRECT: returns to IDLE next edge, no pulse emitted.
- fpcsr_clr_i and wb_fpcsr_set_i in the same cycle: the clear applies first, then the accumulate (result = wb_fpcsr_i flag bits).

## Configuration
- MOR1KX_WB_COMMIT_FPCSR_EN defined: fpcsr_o[11:3] sticky-ORs wb_fpcsr_i[11:3] when wb_fpcsr_set_i & wb_new_i & ~EXC. fpcsr_o[2:0] is loaded from wb_fpcsr_i[2:0] on the same condition. fpcsr_clr_i zeroes [11:3].
- Undefined: fpcsr_o tied 0, FPCSR inputs ignored, no FPCSR register.

## Test plan
- Reset, then wb_new_i with flag_set=1, carry_set=1, carry_clear=1 -> ctrl_flag_o=1, ctrl_carry_o=1 next cycle. sr_sm_o=1 after reset.
- pc_wb_i=0x1000, illegal, excepts_en=1, not DS, F=1 -> T+1: epcr_o=0x1000, esr_o=0x0201, atomic=0. T+1 flush; T+2 redirect_pc_o=0x700.
- Syscall in delay slot at pc 0x2004 with trap also set -> epcr_o=0x2000, sr_dsx_o=1, vector 0xC00.
- Dtlb_miss with lsu_adr_i=0xDEAD0000 and flag_set=1 -> eear_o=0xDEAD0000, ctrl_flag_o unchanged, redirect 0x900.
- RFE after the above (esr_o=0x0201, epcr_o=0x1000) -> F=1, SM=1, flush then redirect_pc_o=0x1000. A wb_new_i during FLUSH is ignored.
- FPCSR_EN: accumulate fpcsr 0x008 then 0x010 -> fpcsr_o[11:3] bits = 0x018. Then fpcsr_clr_i -> [11:3]=0.
